piso_serial_tx: RTL
===================

PISO_SERIAL_TX -- requirements
Module: piso_serial_tx

Parameters
REQ-001 SHALL provide parameter WIDTH, default 8, giving the number of bits per frame (legal range 2..32).
REQ-002 SHALL provide parameter MSB_FIRST, default 1: 1 = MSB transmitted first, 0 = LSB first.

Interface
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: bit-rate strobe; each sampled 1 advances transmission by one bit.
REQ-006 SHALL have port din, input, WIDTH bits: parallel word to transmit.
REQ-007 SHALL have port load_valid, input, 1 bit: din is valid and offered for loading.
REQ-008 SHALL have port load_ready, output, 1 bit: the block accepts a word this cycle.
REQ-009 SHALL have port sdo, output, 1 bit: serial data out.
REQ-010 SHALL have port sdo_valid, output, 1 bit: sdo carries a frame bit.
REQ-011 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-013 SHALL implement the three-state FSM IDLE, SHIFT and DONE, held in a state register plus a WIDTH-bit shift register and a clog2(WIDTH)-bit bit counter.
REQ-014 SHALL drive load_ready = 1 only in IDLE, with load_ready decoded from registered state.
REQ-015 SHALL, in IDLE, on an edge with load_valid=1, capture din into the shift register, clear the counter and enter SHIFT; en is not required for the load.
REQ-016 SHALL, in SHIFT, drive sdo_valid=1 and sdo = the shift-register MSB when MSB_FIRST=1, else the LSB.
REQ-017 SHALL, in SHIFT, on an edge with en=1 and counter < WIDTH-1, shift the register by one toward the output end, fill the vacated bit with 0 and increment the counter.
REQ-018 SHALL, in SHIFT, on an edge with en=1 and counter == WIDTH-1, enter DONE.
REQ-019 SHALL, in SHIFT, on an edge with en=0, hold the shift register, counter and state, so each bit persists until the next en.
REQ-020 SHALL, in DONE, drive done=1, sdo_valid=0 and sdo=0 for exactly one cycle, then enter IDLE unconditionally.
REQ-021 SHALL drive sdo=0 whenever sdo_valid=0.
REQ-022 SHALL drive busy=1 in SHIFT and DONE, and busy=0 in IDLE.
REQ-023 SHALL ignore load_valid whenever load_ready=0; a frame in progress is never altered.
REQ-024 SHALL ignore en in IDLE and in DONE.
REQ-025 SHALL give load-to-done latency = 1 + (number of en-high cycles needed for WIDTH bits); with en tied high, done asserts WIDTH+1 cycles after the load edge.
REQ-026 SHALL allow a new load on the cycle after DONE (IDLE), giving a minimum frame-to-frame spacing of WIDTH+2 cycles with en tied high.

Reset
REQ-027 SHALL, on any rising clk edge with reset=1, force IDLE and clear the shift register and counter, overriding load_valid and en.
REQ-028 SHALL present these values in the cycle after a reset edge: sdo=0, sdo_valid=0, busy=0, done=0, load_ready=1.
REQ-029 SHALL, when reset is asserted mid-frame, abort the frame with no done pulse; the partial frame is lost.

Verification
REQ-030 SHALL be verified by: reset=1 for 2 cycles with load_valid=1 and din=8'hA5 -> no capture, busy=0, sdo_valid=0, and load_ready=1 after release.
REQ-031 SHALL be verified by: load 8'hA5 with en=1 held high -> sdo = 1,0,1,0,0,1,0,1 in cycles 1..8 with sdo_valid=1, done=1 in cycle 9, load_ready=1 in cycle 10.
REQ-032 SHALL be verified by: load 8'h3C with en high on alternate cycles -> each bit held 2 cycles (0,0,1,1,1,1,0,0), and done follows 16 SHIFT cycles.
REQ-033 SHALL be verified by: load 8'hF0, then load_valid=1 with din=8'h0F during SHIFT -> load_ready=0, and the output stream stays 1,1,1,1,0,0,0,0.
REQ-034 SHALL be verified by: reset asserted after the 3rd bit of 8'hA5 -> next cycle busy=0 and sdo_valid=0, done never pulses, and a following load of 8'h81 transmits correctly.
REQ-035 SHALL be verified by: MSB_FIRST=0, load 8'h01 with en high -> sdo = 1,0,0,0,0,0,0,0.

Source files
------------

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out transmitter: loads a WIDTH-bit word when idle and shifts
// it out one bit per en strobe, then emits a one-cycle done pulse.
module piso_serial_tx #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_shreg;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   w_shifted;
  logic               w_last;

  // Shift toward whichever end feeds sdo; the vacated bit is zero-filled.
  always_comb begin
    w_shifted = '0;
    if (MSB_FIRST) begin
      w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
    end else begin
      w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
    end
  end

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (load_valid) begin
            r_shreg <= din;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (en) begin
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_shreg <= w_shifted;
              r_cnt   <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // All outputs are pure decodes of registered state, so they change only on clk.
  assign load_ready = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign sdo_valid  = (r_state == S_SHIFT);
  assign sdo        = sdo_valid & (MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0]);

endmodule
